// File: rtl/mem_arb_pkg.sv
// Shared types for the memory request arbiter: FSM states and the latched command.
// Command fields are sized for the widest supported configuration; the top slices them down.
package mem_arb_pkg;
  localparam int MAX_ADDR_W = 32;
  localparam int MAX_DATA_W = 64;
  localparam int OWNER_W    = 3;  // enough for up to 8 requesters

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_DATA_W-1:0] wdata;
    logic [OWNER_W-1:0]    owner;
  } arb_cmd_t;
endpackage

// File: rtl/mem_req_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, named as the block ports.
interface mem_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_i;
  logic [NUM_REQ-1:0]        req_write_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]        gnt_o;
  logic [NUM_REQ-1:0]        rsp_valid_o;
  logic [DATA_W-1:0]         rsp_data_o;
  logic                      rsp_err_o;
  logic                      mem_read_o;
  logic                      mem_write_o;
  logic [ADDR_W-1:0]         mem_addr_o;
  logic [DATA_W-1:0]         mem_wdata_o;
  logic                      mem_rd_valid_i;
  logic [DATA_W-1:0]         mem_rd_data_i;

  modport slave (
    input  req_i, req_write_i, req_addr_i, req_wdata_i, mem_rd_valid_i, mem_rd_data_i,
    output gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output req_i, req_write_i, req_addr_i, req_wdata_i, mem_rd_valid_i, mem_rd_data_i,
    input  gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o,
           mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_rr_pick.sv
// Round-robin pick: one-hot winner from req_i starting at ptr_q, pointer advances past the winner on upd_i.
module mem_rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               upd_i,
  output logic [NUM_REQ-1:0] pick_oh_o,
  output logic [IDX_W-1:0]   pick_idx_o
);
  logic [IDX_W-1:0] ptr_q, ptr_d, cand;
  int               cand_int;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    pick_oh_o  = '0;
    pick_idx_o = '0;
    cand       = '0;
    cand_int   = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_int = int'(ptr_q) + i;
      if (cand_int >= NUM_REQ) cand_int = cand_int - NUM_REQ;
      cand = IDX_W'(cand_int);
      if (req_i[cand]) begin
        pick_oh_o       = '0;
        pick_oh_o[cand] = 1'b1;
        pick_idx_o      = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (upd_i) ptr_d = (pick_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_o + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one read/write memory port among NUM_REQ requesters: round-robin grant,
// single outstanding read with timeout, read data routed back to its owner.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  mem_req_arbiter_if.slave  bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e         state_q, state_d;
  arb_cmd_t           cmd_q, cmd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic [NUM_REQ-1:0] pick_oh, owner_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               ptr_upd, issue;
  logic               unused_cmd;

  mem_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .clk        (clk),
    .reset      (reset),
    .req_i      (bus.req_i),
    .upd_i      (ptr_upd),
    .pick_oh_o  (pick_oh),
    .pick_idx_o (pick_idx)
  );

  assign owner_oh = NUM_REQ'(1) << cmd_q.owner;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_data_d  = '0;
    rsp_err_d   = 1'b0;
    ptr_upd     = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pick_oh) begin
          ptr_upd     = 1'b1;
          cmd_d.write = bus.req_write_i[pick_idx];
          cmd_d.addr  = MAX_ADDR_W'(bus.req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W]);
          cmd_d.wdata = MAX_DATA_W'(bus.req_wdata_i[int'(pick_idx)*DATA_W +: DATA_W]);
          cmd_d.owner = OWNER_W'(pick_idx);
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = cmd_q.write ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        // Data in the last waiting cycle still beats the timeout.
        if (bus.mem_rd_valid_i) begin
          rsp_valid_d = owner_oh;
          rsp_data_d  = bus.mem_rd_data_i;
          state_d     = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_valid_d = owner_oh;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign issue           = (state_q == ISSUE);
  assign bus.gnt_o       = issue ? owner_oh : '0;
  assign bus.mem_read_o  = issue & ~cmd_q.write;
  assign bus.mem_write_o = issue & cmd_q.write;
  assign bus.mem_addr_o  = issue ? cmd_q.addr[ADDR_W-1:0] : '0;
  assign bus.mem_wdata_o = (issue & cmd_q.write) ? cmd_q.wdata[DATA_W-1:0] : '0;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;

  // Upper command bits beyond ADDR_W/DATA_W are always zero.
  assign unused_cmd = ^cmd_q;
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Round-robin arbiter and sequencer that shares one 32-bit read/write memory port among several requesters. Each requester raises a read or write request. The block grants one request at a time, drives the memory command, and tracks the single outstanding read until data returns. It then routes the read data back to its owner. A timeout guards against a memory that never answers. It sits between the client logic and the memory interface block (read/write command in, `rd_valid`/`rd_data` out).

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `ADDR_W`, 8: memory address width.
- `DATA_W`, 32: data width.
- `RD_TIMEOUT`, 16: cycles waited for `mem_rd_valid_i` before returning an error (≥2).

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `req_i`, in, NUM_REQ: request per requester; held until granted.
- `req_write_i`, in, NUM_REQ: 1 = write, 0 = read.
- `req_addr_i`, in, NUM_REQ*ADDR_W: requester k at `[k*ADDR_W +: ADDR_W]`.
- `req_wdata_i`, in, NUM_REQ*DATA_W: requester k at `[k*DATA_W +: DATA_W]`.
- `gnt_o`, out, NUM_REQ: one-hot, one-cycle grant pulse.
- `rsp_valid_o`, out, NUM_REQ: one-hot, one-cycle read-response pulse.
- `rsp_data_o`, out, DATA_W: read data; valid with `rsp_valid_o`.
- `rsp_err_o`, out, 1: read timed out; valid with `rsp_valid_o`.
- `mem_read_o`, out, 1: one-cycle read command to memory.
- `mem_write_o`, out, 1: one-cycle write command to memory.
- `mem_addr_o`, out, ADDR_W: command address.
- `mem_wdata_o`, out, DATA_W: write data.
- `mem_rd_valid_i`, in, 1: memory read data valid.
- `mem_rd_data_i`, in, DATA_W: memory read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD.
- **IDLE**
  - Any `req_i` bit set: pick the winner round-robin, latch winner index, direction, address and wdata.
  - Go to ISSUE.
- **ISSUE**
  - `gnt_o[winner]`=1 and exactly one of `mem_read_o`/`mem_write_o`=1, with `mem_addr_o`/`mem_wdata_o` from the latched values.
  - Write: go to IDLE.
  - Read: clear the timeout counter and go to WAIT_RD.
- **WAIT_RD**
  - `mem_rd_valid_i`=1: register `mem_rd_data_i` to `rsp_data_o`; next cycle `rsp_valid_o[owner]`=1, `rsp_err_o`=0; go to IDLE.
  - Counter reaches RD_TIMEOUT with no valid: next cycle `rsp_valid_o[owner]`=1, `rsp_err_o`=1, `rsp_data_o`=0; go to IDLE.
- **Round-robin**
  - Priority pointer resets to 0, so requester 0 has highest priority.
  - After granting k, the pointer becomes (k+1) mod NUM_REQ and requester k+1 has highest priority.
  - The pointer updates only on grant.
- **Stray input:** `mem_rd_valid_i` outside WAIT_RD is ignored (late responses after a timeout are dropped).
- **Mid-operation reset:** any in-flight read is abandoned with no response issued. The pointer returns to 0.
- **Reset values:** every output 0; state IDLE.
- **Counter:** width $clog2(RD_TIMEOUT+1) bits; saturates, never wraps.

## Timing
- `req_i` sampled in IDLE at cycle T. `gnt_o` and the memory command are registered and asserted at T+1 (ISSUE).
- The requester must drop or replace `req_i` by T+2. A requester still asserting at T+2 is treated as a new request.
- Write throughput: one command per 2 cycles.
- Memory read latency is ≥1 cycle after `mem_read_o`. `mem_rd_valid_i` is accepted only in WAIT_RD.
- Valid at cycle R gives `rsp_valid_o` at R+1. The next arbitration is at R+1 and the next command at R+2.
- WAIT_RD entered at W with no valid in W..W+RD_TIMEOUT-1 gives the error response at W+RD_TIMEOUT.
- A valid arriving in cycle W+RD_TIMEOUT-1 wins over the timeout.

## Structure
- Package `mem_arb_pkg`: FSM state enum (IDLE, ISSUE, WAIT_RD) and a command struct (write flag, addr, wdata, owner index).
- Sub-module `mem_rr_pick`: combinational one-hot round-robin selection from `req_i` and pointer, plus the pointer register with an update enable.
- The top level holds the FSM, command/owner registers, timeout counter and response registers.

## Test plan
- **Single write:** reset, then requester 2 write addr 0x10 data 0xDEADBEEF → `gnt_o`=4'b0100 and `mem_write_o`=1, addr 0x10, wdata 0xDEADBEEF one cycle later; no `rsp_valid_o`.
- **Single read:** requester 1 reads 0x20, memory returns 0x12345678 three cycles after `mem_read_o` → `rsp_valid_o`=4'b0010 and `rsp_data_o`=0x12345678 the next cycle; `rsp_err_o`=0.
- **Fairness:** all four requesters hold writes continuously → grants 0,1,2,3,0 on cycles 1,3,5,7,9 after reset release.
- **Timeout:** read from requester 3, memory silent → `rsp_valid_o`=4'b1000 and `rsp_err_o`=1 with `rsp_data_o`=0 exactly RD_TIMEOUT cycles after entering WAIT_RD. A late `mem_rd_valid_i` afterwards produces no response.
- **Reset mid-read:** assert `reset` during WAIT_RD → all outputs 0 next cycle. Subsequent `mem_rd_valid_i` is ignored. The next grant goes to requester 0 when all request.
